// File: rtl/spi_master_gen.sv
// spi_master_gen: runtime-configurable SPI master with generic word width,
// CPOL/CPHA, clock divider, bit order, multiple selects and held bursts.
module spi_master_gen #(
   parameter  int unsigned DATA_W = 8,
   parameter  int unsigned NUM_CS = 4,
   parameter  int unsigned DIV_W  = 8,
   localparam int unsigned CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] data_tx,
   input  logic [CS_W-1:0]   cs_sel,
   input  logic              hold,
   input  logic              release_req,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              lsb_first,
   input  logic [DIV_W-1:0]  clk_div,
   input  logic              miso,
   output logic              sck,
   output logic              mosi,
   output logic [NUM_CS-1:0] cs_n,
   output logic [DATA_W-1:0] data_rx,
   output logic              rx_valid,
   output logic              busy,
   output logic              ready
);
   localparam int unsigned       ECNT_W    = $clog2(2 * DATA_W) + 1;
   localparam logic [ECNT_W-1:0] LAST_EDGE = ECNT_W'(2 * DATA_W);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HELD, CS_END} state_t;

   state_t              state, state_d;
   logic                sck_d, mosi_d, rx_valid_d;
   logic [NUM_CS-1:0]   cs_n_d;
   logic [DATA_W-1:0]   data_rx_d;
   logic                cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d, hold_q, hold_d;
   logic [DIV_W-1:0]    div_q, div_d, hcnt, hcnt_d;
   logic [CS_W-1:0]     sel_q, sel_d;
   logic [ECNT_W-1:0]   ecnt, ecnt_d, edge_k;
   logic [DATA_W-1:0]   tx_sr, tx_d, rx_sr, rx_d;
   logic                accept, tick, do_edge;

   function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
      return lsb ? w[0] : w[DATA_W-1];
   endfunction

   function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
      return lsb ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
   endfunction

   function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic lsb,
                                                  input logic b);
      return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
   endfunction

   // Status decodes straight from the state register.
   always_comb begin
      busy  = (state != IDLE);
      ready = (state == IDLE) || ((state == HELD) && (cs_sel == sel_q));
   end

   // Next-state and next-output logic; every register defaults to holding.
   always_comb begin
      state_d    = state;
      sck_d      = sck;
      mosi_d     = mosi;
      cs_n_d     = cs_n;
      data_rx_d  = data_rx;
      rx_valid_d = 1'b0;
      cpol_d     = cpol_q;
      cpha_d     = cpha_q;
      lsb_d      = lsb_q;
      hold_d     = hold_q;
      div_d      = div_q;
      sel_d      = sel_q;
      hcnt_d     = hcnt;
      ecnt_d     = ecnt;
      tx_d       = tx_sr;
      rx_d       = rx_sr;
      accept     = 1'b0;
      tick       = (hcnt == div_q);
      do_edge    = 1'b0;
      edge_k     = ecnt + ECNT_W'(1);

      case (state)
         IDLE: begin
            sck_d = cpol;
            if (start) begin
               accept  = 1'b1;
               cpol_d  = cpol;
               cpha_d  = cpha;
               lsb_d   = lsb_first;
               div_d   = clk_div;
               sel_d   = cs_sel;
               for (int unsigned i = 0; i < NUM_CS; i++) begin
                  cs_n_d[i] = (cs_sel != CS_W'(i));
               end
               state_d = SETUP;
            end
         end
         SETUP: begin
            hcnt_d = hcnt + DIV_W'(1);
            if (tick) begin
               hcnt_d  = '0;
               do_edge = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            hcnt_d = hcnt + DIV_W'(1);
            if (tick) begin
               hcnt_d = '0;
               if (ecnt == LAST_EDGE) begin
                  ecnt_d     = '0;
                  data_rx_d  = rx_sr;
                  rx_valid_d = 1'b1;
                  state_d    = hold_q ? HELD : CS_END;
               end else begin
                  do_edge = 1'b1;
               end
            end
         end
         HELD: begin
            sck_d = cpol_q;
            if (start && (cs_sel == sel_q)) begin
               accept  = 1'b1;
               state_d = SETUP;
            end else if (release_req) begin
               state_d = CS_END;
            end
         end
         CS_END: begin
            hcnt_d = hcnt + DIV_W'(1);
            if (tick) begin
               hcnt_d  = '0;
               cs_n_d  = '1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Word load, shared by the IDLE and HELD accept paths.
      if (accept) begin
         hold_d = hold;
         hcnt_d = '0;
         ecnt_d = '0;
         rx_d   = '0;
         tx_d   = data_tx;
         if (!cpha_d) begin
            mosi_d = first_bit(data_tx, lsb_d);
            tx_d   = shift_out(data_tx, lsb_d);
         end
      end

      // One sck edge: odd edges lead; sample on leading when cpha=0, trailing when cpha=1.
      if (do_edge) begin
         ecnt_d = edge_k;
         sck_d  = ~sck;
         if (edge_k[0] ^ cpha_q) begin
            rx_d = shift_in(rx_sr, lsb_q, miso);
         end else if (edge_k != LAST_EDGE) begin
            mosi_d = first_bit(tx_sr, lsb_q);
            tx_d   = shift_out(tx_sr, lsb_q);
         end
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         sck      <= 1'b0;
         mosi     <= 1'b0;
         cs_n     <= '1;
         data_rx  <= '0;
         rx_valid <= 1'b0;
         cpol_q   <= 1'b0;
         cpha_q   <= 1'b0;
         lsb_q    <= 1'b0;
         hold_q   <= 1'b0;
         div_q    <= '0;
         sel_q    <= '0;
         hcnt     <= '0;
         ecnt     <= '0;
         tx_sr    <= '0;
         rx_sr    <= '0;
      end else begin
         state    <= state_d;
         sck      <= sck_d;
         mosi     <= mosi_d;
         cs_n     <= cs_n_d;
         data_rx  <= data_rx_d;
         rx_valid <= rx_valid_d;
         cpol_q   <= cpol_d;
         cpha_q   <= cpha_d;
         lsb_q    <= lsb_d;
         hold_q   <= hold_d;
         div_q    <= div_d;
         sel_q    <= sel_d;
         hcnt     <= hcnt_d;
         ecnt     <= ecnt_d;
         tx_sr    <= tx_d;
         rx_sr    <= rx_d;
      end
   end
endmodule

// File: tb/tb_spi_master_gen.sv
// tb_spi_master_gen: scoreboard bench with a behavioural SPI slave model.
module tb_spi_master_gen;
   localparam int DW   = 8;
   localparam int NCS  = 3;
   localparam int DIVW = 8;
   localparam int CSW  = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic [DW-1:0]   data_tx = '0;
   logic [CSW-1:0]  cs_sel = '0;
   logic            hold = 1'b0;
   logic            release_req = 1'b0;
   logic            cpol = 1'b0;
   logic            cpha = 1'b0;
   logic            lsb_first = 1'b0;
   logic [DIVW-1:0] clk_div = '0;
   logic            miso;
   logic            sck, mosi, rx_valid, busy, ready;
   logic [NCS-1:0]  cs_n;
   logic [DW-1:0]   data_rx;

   spi_master_gen #(.DATA_W(DW), .NUM_CS(NCS), .DIV_W(DIVW)) dut (
      .clk(clk), .rst(rst), .start(start), .data_tx(data_tx), .cs_sel(cs_sel),
      .hold(hold), .release_req(release_req), .cpol(cpol), .cpha(cpha),
      .lsb_first(lsb_first), .clk_div(clk_div), .miso(miso), .sck(sck), .mosi(mosi),
      .cs_n(cs_n), .data_rx(data_rx), .rx_valid(rx_valid), .busy(busy), .ready(ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Slave model: counts sck edges while the master is busy, shifts its word
   // out on the master's drive edges and captures mosi on the sample edges.
   logic [DW-1:0] slv_words [2];
   logic [DW-1:0] cap_sr = '0, slv_cap = '0, slv_cur;
   logic          slv_miso = 1'b0, sck_prev = 1'b0, busy_prev = 1'b0;
   logic          loopback = 1'b1, s_cpha = 1'b0, s_lsb = 1'b0;
   int            sc = 0, cap_n = 0, s_pos, s_w;
   assign miso = loopback ? mosi : slv_miso;

   always @(negedge clk) begin
      if (busy !== 1'b1) begin
         sc = 0;
         cap_n = 0;
         slv_miso = 1'b0;
      end else begin
         if (busy_prev && (sck !== sck_prev)) begin
            sc++;
            if (((sc % 2) == 1) != (s_cpha == 1'b1)) begin
               cap_sr = s_lsb ? {mosi, cap_sr[DW-1:1]} : {cap_sr[DW-2:0], mosi};
               cap_n++;
               if (cap_n % DW == 0) slv_cap = cap_sr;
            end
         end
         s_pos = s_cpha ? ((sc == 0) ? 0 : (sc - 1) / 2) : sc / 2;
         s_w = s_pos / DW;
         if (s_w > 1) s_w = 1;
         slv_cur = slv_words[s_w];
         slv_miso = s_lsb ? slv_cur[s_pos % DW] : slv_cur[DW - 1 - (s_pos % DW)];
      end
      sck_prev = sck;
      busy_prev = busy;
   end

   // Scoreboard of expected received words.
   typedef struct {
      logic [DW-1:0]  rx;
      logic [DW-1:0]  tx;
      int             cyc;
      logic [NCS-1:0] cs;
      int             edges;
   } exp_t;
   exp_t sbq[$];
   exp_t mon_e;

   always @(negedge clk) begin
      if (rx_valid === 1'b1) begin
         if (sbq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rx_unexpected: data_rx=%0h with nothing expected (cycle %0d)", data_rx, cyc);
         end else begin
            mon_e = sbq.pop_front();
            check("rx_data", 32'(data_rx), 32'(mon_e.rx));
            check("rx_cycle", cyc, mon_e.cyc);
            check("mosi_word", 32'(slv_cap), 32'(mon_e.tx));
            check("rx_cs_n", 32'(cs_n), 32'(mon_e.cs));
            check("sck_edges", sc, mon_e.edges);
         end
      end
   end

   // Continuous-select watch used across the burst.
   logic cs_watch = 1'b0;
   int   cs_viol = 0;
   always @(negedge clk) if (cs_watch && cs_n[2] !== 1'b0) cs_viol++;

   int last_acc = 0;

   task automatic issue(input logic [CSW-1:0] sel, input logic [DW-1:0] tx, input logic [DW-1:0] rxw,
                        input logic hld, input logic rel, input logic pol, input logic pha,
                        input logic lsb, input logic [DIVW-1:0] dv, input int widx);
      exp_t e;
      logic [NCS-1:0] m;
      m = '1;
      if (int'(sel) < NCS) m[sel] = 1'b0;
      cs_sel = sel; data_tx = tx; hold = hld; release_req = rel;
      cpol = pol; cpha = pha; lsb_first = lsb; clk_div = dv;
      s_cpha = pha; s_lsb = lsb;
      slv_words[widx] = rxw;
      e.rx = loopback ? tx : rxw;
      e.tx = tx;
      e.cyc = cyc + 1 + (int'(dv) + 1) * (2 * DW + 1);
      e.cs = m;
      e.edges = 2 * DW * (widx + 1);
      sbq.push_back(e);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      release_req = 1'b0;
      last_acc = cyc;
   endtask

   task automatic wait_ready(input int budget, output int at);
      int n;
      n = 0;
      while (ready !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (ready !== 1'b1) begin
         n_tests++;
         n_fail++;
         $display("FAIL ready_timeout: ready=%b after %0d cycles, required 1", ready, n);
      end
      at = cyc;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int at, acc, r, n;
      logic [DW-1:0] tx, rxw;
      logic [CSW-1:0] sel;
      logic pol, pha, lsb;
      logic [DIVW-1:0] dv;
      slv_words[0] = '0;
      slv_words[1] = '0;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_sck", 32'(sck), 32'd0);
      check("rst_mosi", 32'(mosi), 32'd0);
      check("rst_cs_n", 32'(cs_n), 32'h7);
      check("rst_data_rx", 32'(data_rx), 32'd0);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(ready), 32'd1);
      rst = 1'b0;
      @(negedge clk);

      // Mode 0, H=1, loopback, plus a start while busy
      loopback = 1'b1;
      issue(2'd0, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 0);
      acc = last_acc;
      check("cs_low_after_accept", 32'(cs_n), 32'h6);
      check("busy_in_xfer", 32'(busy), 32'd1);
      check("ready_in_xfer", 32'(ready), 32'd0);
      cs_sel = 2'd1; data_tx = 8'hFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0; cs_sel = 2'd0;
      wait_ready(2000, at);
      check("ready_ret_m0", at, acc + 18);
      check("idle_cs_n_m0", 32'(cs_n), 32'h7);
      check("idle_sck_m0", 32'(sck), 32'd0);

      // Mode 3, H=4, slave returns 0xC3
      loopback = 1'b0;
      cpol = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_sck_cpol1", 32'(sck), 32'd1);
      issue(2'd1, 8'h3C, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd3, 0);
      acc = last_acc;
      wait_ready(2000, at);
      check("ready_ret_m3", at, acc + 4 * 18);
      check("idle_sck_m3", 32'(sck), 32'd1);

      // LSB-first, mode 1: mosi high on the first bit only
      issue(2'd0, 8'h01, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 0);
      @(negedge clk);
      check("lsb_first_bit", 32'(mosi), 32'd1);
      repeat (2) @(negedge clk);
      check("lsb_second_bit", 32'(mosi), 32'd0);
      wait_ready(2000, at);

      // Held burst on cs 2
      slv_words[1] = 8'hE7;
      issue(2'd2, 8'h12, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 0);
      acc = last_acc;
      cs_watch = 1'b1;
      wait_ready(2000, at);
      check("held_ready_cycle", at, acc + 2 * 17);
      check("held_busy", 32'(busy), 32'd1);
      cs_sel = 2'd1;
      #1;
      check("held_wrong_sel_ready", 32'(ready), 32'd0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0; cs_sel = 2'd2;
      #1;
      check("held_wrong_sel_ignored", 32'(ready), 32'd1);
      issue(2'd2, 8'h34, 8'hE7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 1);
      acc = last_acc;
      wait_ready(2000, at);
      check("held_ready_cycle2", at, acc + 2 * 17);
      release_req = 1'b1;
      @(negedge clk);
      release_req = 1'b0;
      cs_watch = 1'b0;
      r = cyc;
      n = 0;
      while (cs_n !== 3'b111 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("release_cs_high_cycle", cyc, r + 2);
      check("burst_cs_continuous", cs_viol, 0);
      wait_ready(2000, at);

      // cs_sel beyond NUM_CS: no select, transfer still runs
      loopback = 1'b1;
      issue(2'd3, 8'h96, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 0);
      wait_ready(2000, at);

      // Reset mid-word, then a clean transfer
      issue(2'd1, 8'h5C, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 0);
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sbq.delete();
      check("midrst_cs_n", 32'(cs_n), 32'h7);
      check("midrst_sck", 32'(sck), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_rx_valid", 32'(rx_valid), 32'd0);
      check("midrst_data_rx", 32'(data_rx), 32'd0);
      repeat (40) @(negedge clk);
      issue(2'd1, 8'hC9, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 0);
      wait_ready(2000, at);

      // Randomized transfers
      for (int i = 0; i < 12; i++) begin
         sel = CSW'($urandom_range(0, 3));
         tx  = DW'($urandom);
         rxw = DW'($urandom);
         pol = 1'($urandom_range(0, 1));
         pha = 1'($urandom_range(0, 1));
         lsb = 1'($urandom_range(0, 1));
         dv  = DIVW'($urandom_range(0, 3));
         loopback = 1'($urandom_range(0, 1));
         issue(sel, tx, rxw, 1'b0, 1'b0, pol, pha, lsb, dv, 0);
         acc = last_acc;
         wait_ready(2000, at);
         check("rand_ready_ret", at, acc + (int'(dv) + 1) * 18);
         check("rand_idle_sck", 32'(sck), 32'(pol));
      end

      repeat (3) @(negedge clk);
      check("sb_drained", sbq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
